// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - register-file/ALU operation sequencer (RD -> EX -> WB -> RSP)
// Optional signed-overflow trap on ADD/SUB enabled by defining OVF_TRAP_EN.
module regfile_op_sequencer #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req_Valid,
    output logic          Req_Ready,
    input  logic [AW-1:0] Req_Rs1,
    input  logic [AW-1:0] Req_Rs2,
    input  logic [AW-1:0] Req_Rd,
    input  logic [3:0]    Req_Op,
    input  logic [4:0]    Req_Shamt,
    input  logic          Req_Wb,
    output logic [AW-1:0] RR1,
    output logic [AW-1:0] RR2,
    input  logic [DW-1:0] Out1,
    input  logic [DW-1:0] Out2,
    output logic [AW-1:0] WR,
    output logic [DW-1:0] WD,
    output logic          WE,
    output logic [DW-1:0] Alu_A,
    output logic [DW-1:0] Alu_B,
    output logic [3:0]    Alu_Op,
    output logic [4:0]    Alu_Shamt,
    input  logic [DW-1:0] Alu_Result,
    output logic          Rsp_Valid,
    output logic [DW-1:0] Rsp_Data,
    output logic          Rsp_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB,
        S_RSP
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rs1_q, rs2_q, rd_q;
    logic [3:0]    op_q;
    logic [4:0]    shamt_q;
    logic          wb_q;
    logic [DW-1:0] a_q, b_q, res_q, rsp_data_q;
    logic          err_q, rsp_err_q;
    logic          accept, op_legal, ovf;

    assign accept = Req_Valid && Req_Ready;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

`ifdef OVF_TRAP_EN
    // ADD: same operand signs, result sign flips; SUB: operand signs differ, result sign differs from A
    always_comb begin
        ovf = 1'b0;
        if (op_q == 4'b0010)
            ovf = (a_q[DW-1] == b_q[DW-1]) && (Alu_Result[DW-1] != a_q[DW-1]);
        else if (op_q == 4'b0110)
            ovf = (a_q[DW-1] != b_q[DW-1]) && (Alu_Result[DW-1] != a_q[DW-1]);
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RD;
            S_RD:    state_nxt = S_EX;
            S_EX:    state_nxt = S_WB;
            S_WB:    state_nxt = S_RSP;
            S_RSP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            shamt_q    <= '0;
            wb_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q     <= Req_Rs1;
                        rs2_q     <= Req_Rs2;
                        rd_q      <= Req_Rd;
                        op_q      <= Req_Op;
                        shamt_q   <= Req_Shamt;
                        wb_q      <= Req_Wb;
                        err_q     <= 1'b0;
                        rsp_err_q <= 1'b0;
                    end
                end
                S_RD: begin
                    a_q <= Out1;
                    b_q <= Out2;
                end
                S_EX: begin
                    res_q <= op_legal ? Alu_Result : '0;
                    err_q <= !op_legal || ovf;
                end
                S_RSP: begin
                    rsp_data_q <= res_q;
                    rsp_err_q  <= err_q;
                end
                default: ;
            endcase
        end
    end

    assign Req_Ready = (state == S_IDLE);
    assign RR1       = rs1_q;
    assign RR2       = rs2_q;
    assign Alu_A     = a_q;
    assign Alu_B     = b_q;
    assign Alu_Op    = op_q;
    assign Alu_Shamt = shamt_q;
    assign WR        = rd_q;
    assign WD        = res_q;
    // Decoded from state so an asynchronous reset drops the write strobe at once
    assign WE        = (state == S_WB) && wb_q && !err_q;
    assign Rsp_Valid = (state == S_RSP);
    assign Rsp_Data  = (state == S_RSP) ? res_q : rsp_data_q;
    assign Rsp_Err   = (state == S_RSP) ? err_q : rsp_err_q;

endmodule
